// File: rtl/command_channel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// command_channel_arbiter_pkg
// Shared definitions for the command channel arbiter slice.
//   - Arbiter FSM state encoding (Idle / Forward).
//   - Fixed command field widths of the standard command bundle.
//   - Slice-offset helper for the packed per-source input bundles.
// Optional feature macro used by the arbiter: CMD_ARB_PRIORITY0_EN.
// -----------------------------------------------------------------------------
package command_channel_arbiter_pkg;

    localparam int OpcodeWidth = 6;
    localparam int IDWidth     = 5;

    typedef enum logic {
        State_Idle    = 1'b0,
        State_Forward = 1'b1
    } state_t;

    // Source k of a packed bundle with field width W occupies [k*W +: W].
    function automatic int sliceOffset(input int index, input int width);
        return index * width;
    endfunction

endpackage

// File: rtl/command_channel_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. Searches the request vector starting at
// iLastGrant+1 (wrapping modulo NumSources) and returns the first requester.
// Ports:
//   iRequest    : per-source request bits
//   iLastGrant  : index of the most recent round-robin grant
//   oGrant      : one-hot grant (zero when no request)
//   oGrantID    : index of the granted source (zero when no request)
//   oGrantValid : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NumSources   = 4,
    parameter int GrantIDWidth = 2
) (
    input  logic [NumSources-1:0]   iRequest,
    input  logic [GrantIDWidth-1:0] iLastGrant,
    output logic [NumSources-1:0]   oGrant,
    output logic [GrantIDWidth-1:0] oGrantID,
    output logic                    oGrantValid
);

    always_comb begin : search
        int candidate;
        oGrant      = '0;
        oGrantID    = '0;
        oGrantValid = 1'b0;
        candidate   = 0;
        for (int offset = 1; offset <= NumSources; offset++) begin
            candidate = (int'(iLastGrant) + offset) % NumSources;
            if (!oGrantValid && iRequest[candidate]) begin
                oGrant[candidate] = 1'b1;
                oGrantID          = GrantIDWidth'(candidate);
                oGrantValid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_channel_arbiter.sv
// -----------------------------------------------------------------------------
// command_channel_arbiter
// Round-robin arbiter sharing one downstream command channel among NumSources
// requesters. One command is accepted per Idle cycle into a single output
// register stage and held until the downstream accepts it. Zero-length
// commands are accepted and dropped without a downstream beat.
// Optional feature: define CMD_ARB_PRIORITY0_EN to give source 0 strict
// priority (its grants do not move the round-robin pointer).
// Ports:
//   iClock, iReset (async, active-low)
//   iSrc{Opcode,TargetID,SourceID,Address,Length} : packed per-source fields
//   iSrcCmdValid / oSrcCmdReady                   : per-source handshake
//   oDst{Opcode,TargetID,SourceID,Address,Length} : registered command
//   oDstCmdValid / iDstCmdReady                   : downstream handshake
//   oDstGrantID                                   : index of presented source
// -----------------------------------------------------------------------------
module command_channel_arbiter
    import command_channel_arbiter_pkg::*;
#(
    parameter int NumSources         = 4,
    parameter int AddressWidth       = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int GrantIDWidth       = 2
) (
    input  logic                                     iClock,
    input  logic                                     iReset,
    input  logic [OpcodeWidth*NumSources-1:0]        iSrcOpcode,
    input  logic [IDWidth*NumSources-1:0]            iSrcTargetID,
    input  logic [IDWidth*NumSources-1:0]            iSrcSourceID,
    input  logic [AddressWidth*NumSources-1:0]       iSrcAddress,
    input  logic [InnerIFLengthWidth*NumSources-1:0] iSrcLength,
    input  logic [NumSources-1:0]                    iSrcCmdValid,
    output logic [NumSources-1:0]                    oSrcCmdReady,
    output logic [OpcodeWidth-1:0]                   oDstOpcode,
    output logic [IDWidth-1:0]                       oDstTargetID,
    output logic [IDWidth-1:0]                       oDstSourceID,
    output logic [AddressWidth-1:0]                  oDstAddress,
    output logic [InnerIFLengthWidth-1:0]            oDstLength,
    output logic                                     oDstCmdValid,
    input  logic                                     iDstCmdReady,
    output logic [GrantIDWidth-1:0]                  oDstGrantID
);

    state_t                    rState, wNextState;
    logic [GrantIDWidth-1:0]   rLastGrant;
    logic [NumSources-1:0]     wRrRequest, wRrGrant, wWinGrant;
    logic [GrantIDWidth-1:0]   wRrGrantID, wWinID;
    logic                      wRrValid, wWinValid, wUpdateLast, wHandshake;
    logic [InnerIFLengthWidth-1:0] wWinLength;

    rr_priority_picker #(
        .NumSources  (NumSources),
        .GrantIDWidth(GrantIDWidth)
    ) uPicker (
        .iRequest   (wRrRequest),
        .iLastGrant (rLastGrant),
        .oGrant     (wRrGrant),
        .oGrantID   (wRrGrantID),
        .oGrantValid(wRrValid)
    );

`ifdef CMD_ARB_PRIORITY0_EN
    // Source 0 bypasses the round-robin search; the picker only sees the rest.
    assign wRrRequest = {iSrcCmdValid[NumSources-1:1], 1'b0};

    always_comb begin
        if (iSrcCmdValid[0]) begin
            wWinGrant   = NumSources'(1);
            wWinID      = '0;
            wWinValid   = 1'b1;
            wUpdateLast = 1'b0;
        end else begin
            wWinGrant   = wRrGrant;
            wWinID      = wRrGrantID;
            wWinValid   = wRrValid;
            wUpdateLast = 1'b1;
        end
    end
`else
    assign wRrRequest  = iSrcCmdValid;
    assign wWinGrant   = wRrGrant;
    assign wWinID      = wRrGrantID;
    assign wWinValid   = wRrValid;
    assign wUpdateLast = 1'b1;
`endif

    assign wWinLength = iSrcLength[sliceOffset(int'(wWinID), InnerIFLengthWidth) +: InnerIFLengthWidth];
    assign wHandshake = (rState == State_Idle) && wWinValid;

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) rState <= State_Idle;
        else         rState <= wNextState;
    end

    // Next-state logic
    always_comb begin
        wNextState = rState;
        case (rState)
            State_Idle:    if (wHandshake && (wWinLength != '0)) wNextState = State_Forward;
            State_Forward: if (iDstCmdReady) wNextState = State_Idle;
            default:       wNextState = State_Idle;
        endcase
    end

    // Output logic; ready is gated by reset so nothing is accepted while held in reset.
    always_comb begin
        oSrcCmdReady = '0;
        oDstCmdValid = 1'b0;
        case (rState)
            State_Idle:    if (iReset) oSrcCmdReady = wWinGrant;
            State_Forward: oDstCmdValid = 1'b1;
            default:       oDstCmdValid = 1'b0;
        endcase
    end

    // Output register stage: captured on every source handshake, including
    // zero-length commands that never produce a downstream beat.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rLastGrant   <= GrantIDWidth'(NumSources - 1);
            oDstOpcode   <= '0;
            oDstTargetID <= '0;
            oDstSourceID <= '0;
            oDstAddress  <= '0;
            oDstLength   <= '0;
            oDstGrantID  <= '0;
        end else if (wHandshake) begin
            if (wUpdateLast) rLastGrant <= wWinID;
            oDstOpcode   <= iSrcOpcode  [sliceOffset(int'(wWinID), OpcodeWidth)        +: OpcodeWidth];
            oDstTargetID <= iSrcTargetID[sliceOffset(int'(wWinID), IDWidth)            +: IDWidth];
            oDstSourceID <= iSrcSourceID[sliceOffset(int'(wWinID), IDWidth)            +: IDWidth];
            oDstAddress  <= iSrcAddress [sliceOffset(int'(wWinID), AddressWidth)       +: AddressWidth];
            oDstLength   <= wWinLength;
            oDstGrantID  <= wWinID;
        end
    end

endmodule

// File: tb/tb_command_channel_arbiter.sv
module tb_command_channel_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int GW = 2;

    logic            iClock = 1'b0;
    logic            iReset;
    logic [6*N-1:0]  iSrcOpcode;
    logic [5*N-1:0]  iSrcTargetID;
    logic [5*N-1:0]  iSrcSourceID;
    logic [AW*N-1:0] iSrcAddress;
    logic [LW*N-1:0] iSrcLength;
    logic [N-1:0]    iSrcCmdValid;
    logic [N-1:0]    oSrcCmdReady;
    logic [5:0]      oDstOpcode;
    logic [4:0]      oDstTargetID;
    logic [4:0]      oDstSourceID;
    logic [AW-1:0]   oDstAddress;
    logic [LW-1:0]   oDstLength;
    logic            oDstCmdValid;
    logic            iDstCmdReady;
    logic [GW-1:0]   oDstGrantID;

    command_channel_arbiter #(
        .NumSources(N), .AddressWidth(AW), .InnerIFLengthWidth(LW), .GrantIDWidth(GW)
    ) dut (
        .iClock(iClock), .iReset(iReset),
        .iSrcOpcode(iSrcOpcode), .iSrcTargetID(iSrcTargetID), .iSrcSourceID(iSrcSourceID),
        .iSrcAddress(iSrcAddress), .iSrcLength(iSrcLength),
        .iSrcCmdValid(iSrcCmdValid), .oSrcCmdReady(oSrcCmdReady),
        .oDstOpcode(oDstOpcode), .oDstTargetID(oDstTargetID), .oDstSourceID(oDstSourceID),
        .oDstAddress(oDstAddress), .oDstLength(oDstLength),
        .oDstCmdValid(oDstCmdValid), .iDstCmdReady(iDstCmdReady), .oDstGrantID(oDstGrantID)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [5:0]    op;
        logic [4:0]    tid;
        logic [4:0]    sid;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            gid;
    } cmd_t;

    cmd_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    // Requester-side staging; copied onto the DUT pins at each falling edge.
    logic [5:0]    sOp[N];
    logic [4:0]    sTid[N];
    logic [4:0]    sSid[N];
    logic [AW-1:0] sAddr[N];
    logic [LW-1:0] sLen[N];
    logic          sVld[N];

    // Reference model: last round-robin winner and whether a beat is outstanding.
    int mLast;
    bit mBusy;
    int grantLog[$];
    int grantCyc[$];
    int cyc = 0;
    bit autoDrop = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic newFields(input int k, input bit allowZero);
        sOp[k]   = 6'($urandom);
        sTid[k]  = 5'($urandom);
        sSid[k]  = 5'($urandom);
        sAddr[k] = $urandom;
        if (allowZero && $urandom_range(0, 7) == 0) sLen[k] = '0;
        else sLen[k] = LW'($urandom_range(1, 65535));
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            iSrcOpcode[k*6 +: 6]     = sOp[k];
            iSrcTargetID[k*5 +: 5]   = sTid[k];
            iSrcSourceID[k*5 +: 5]   = sSid[k];
            iSrcAddress[k*AW +: AW]  = sAddr[k];
            iSrcLength[k*LW +: LW]   = sLen[k];
            iSrcCmdValid[k]          = sVld[k];
        end
    endtask

    function automatic int refWinner();
`ifdef CMD_ARB_PRIORITY0_EN
        if (sVld[0]) return 0;
`endif
        for (int s = 1; s <= N; s++) begin
            if (sVld[(mLast + s) % N]) return (mLast + s) % N;
        end
        return -1;
    endfunction

    // One clock cycle: apply staged inputs, check ready, advance the model.
    task automatic step(input bit dRdy);
        int w;
        logic [N-1:0] expRdy;
        @(negedge iClock);
        drive();
        iDstCmdReady = dRdy;
        cyc++;
        #2;
        expRdy = '0;
        w = -1;
        if (!mBusy) begin
            w = refWinner();
            if (w >= 0) expRdy[w] = 1'b1;
        end
        check("src_ready", 64'(oSrcCmdReady), 64'(expRdy));
        if (mBusy) begin
            if (dRdy) mBusy = 1'b0;
        end else if (w >= 0) begin
            grantLog.push_back(w);
            grantCyc.push_back(cyc);
`ifdef CMD_ARB_PRIORITY0_EN
            if (w != 0) mLast = w;
`else
            mLast = w;
`endif
            if (sLen[w] != '0) begin
                expQ.push_back('{op: sOp[w], tid: sTid[w], sid: sSid[w],
                                 addr: sAddr[w], len: sLen[w], gid: w});
                mBusy = 1'b1;
            end
            if (autoDrop) sVld[w] = 1'b0;
            else newFields(w, 1'b0);
        end
    endtask

    task automatic clearSources();
        for (int k = 0; k < N; k++) begin
            sVld[k] = 1'b0;
            newFields(k, 1'b0);
        end
    endtask

    // Assert reset asynchronously mid-cycle, check all outputs cleared, release.
    task automatic doReset();
        @(negedge iClock);
        #3;
        iReset = 1'b0;
        #1;
        check("rst_dst_valid", 64'(oDstCmdValid), 64'(0));
        check("rst_src_ready", 64'(oSrcCmdReady), 64'(0));
        check("rst_fields", {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength},
              64'(0));
        check("rst_grant_id", 64'(oDstGrantID), 64'(0));
        expQ.delete();
        mBusy = 1'b0;
        mLast = N - 1;
        grantLog.delete();
        grantCyc.delete();
        clearSources();
        @(negedge iClock);
        drive();
        iDstCmdReady = 1'b0;
        iReset = 1'b1;
    endtask

    task automatic checkGrants(input string name, input int exp[$]);
        check({name, "_count"}, 64'(grantLog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grantLog.size(); i++)
            check(name, 64'(grantLog[i]), 64'(exp[i]));
    endtask

    // Monitor: whenever the DUT presents a command, compare with the scoreboard head.
    initial begin
        forever begin
            @(negedge iClock);
            #1;
            if (iReset === 1'b1) begin
                check("dst_valid", 64'(oDstCmdValid), 64'(expQ.size() != 0));
                if (oDstCmdValid && expQ.size() != 0) begin
                    check("dst_opcode",   64'(oDstOpcode),   64'(expQ[0].op));
                    check("dst_target",   64'(oDstTargetID), 64'(expQ[0].tid));
                    check("dst_source",   64'(oDstSourceID), 64'(expQ[0].sid));
                    check("dst_address",  64'(oDstAddress),  64'(expQ[0].addr));
                    check("dst_length",   64'(oDstLength),   64'(expQ[0].len));
                    check("dst_grant_id", 64'(oDstGrantID),  64'(expQ[0].gid));
                    if (iDstCmdReady) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        iReset = 1'b1;
        iDstCmdReady = 1'b0;
        clearSources();
        for (int k = 0; k < N; k++) sVld[k] = 1'b1;
        drive();
        #1 iReset = 1'b0;
        #2;
        check("init_dst_valid", 64'(oDstCmdValid), 64'(0));
        check("init_src_ready", 64'(oSrcCmdReady), 64'(0));
        check("init_fields", {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength},
              64'(0));
        check("init_grant_id", 64'(oDstGrantID), 64'(0));
        doReset();

        // Single source with downstream stall
        sVld[2] = 1'b1; sAddr[2] = 32'h1000; sLen[2] = 16'd8;
        step(1'b0);
        step(1'b0);
        check("single_valid", 64'(oDstCmdValid), 64'(1));
        check("single_addr",  64'(oDstAddress),  64'h1000);
        check("single_len",   64'(oDstLength),   64'(8));
        check("single_gid",   64'(oDstGrantID),  64'(2));
        for (int i = 0; i < 4; i++) step(1'b0);
        check("single_hold_addr", 64'(oDstAddress), 64'h1000);
        step(1'b1);
        step(1'b0);
        check("single_idle", 64'(oDstCmdValid), 64'(0));
        checkGrants("single_order", '{2});

`ifdef CMD_ARB_PRIORITY0_EN
        // Strict priority for source 0
        doReset();
        autoDrop = 1'b0;
        sVld[0] = 1'b1; sVld[1] = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1);
        checkGrants("prio_order", '{0, 0, 0, 0});
        sVld[0] = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1);
        checkGrants("prio_drop0", '{0, 0, 0, 0, 1, 1});
        autoDrop = 1'b1;
`else
        // All sources continuously valid, downstream always ready
        doReset();
        autoDrop = 1'b0;
        for (int k = 0; k < N; k++) sVld[k] = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1);
        checkGrants("rr_order", '{0, 1, 2, 3, 0, 1});
        for (int i = 1; i < grantCyc.size(); i++)
            check("rr_spacing", 64'(grantCyc[i] - grantCyc[i-1]), 64'(2));
        autoDrop = 1'b1;
`endif

        // Zero-length command is consumed without a downstream beat
        doReset();
        sVld[1] = 1'b1; sLen[1] = '0;
        step(1'b0);
        step(1'b0);
        check("zero_no_valid", 64'(oDstCmdValid), 64'(0));
        for (int k = 0; k < N; k++) begin
            sVld[k] = 1'b1;
            newFields(k, 1'b0);
        end
        step(1'b0);
        checkGrants("zero_next", '{1, 2});
        step(1'b1);

        // Backpressure while other sources wait
        doReset();
        sVld[0] = 1'b1;
        step(1'b0);
        sVld[1] = 1'b1; sVld[3] = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        checkGrants("bp_order", '{0, 1, 3});

        // Reset while a command is being presented
        doReset();
        sVld[2] = 1'b1; sLen[2] = 16'd5;
        step(1'b0);
        step(1'b0);
        check("pre_reset_valid", 64'(oDstCmdValid), 64'(1));
        doReset();
        for (int k = 0; k < N; k++) sVld[k] = 1'b1;
        step(1'b0);
        checkGrants("post_reset_first", '{0});
        step(1'b1);

        // Randomized traffic
        doReset();
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (sVld[k]) begin
                    if ($urandom_range(0, 9) == 0) sVld[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    sVld[k] = 1'b1;
                    newFields(k, 1'b1);
                end
            end
            autoDrop = ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 2) != 0);
        end
        for (int k = 0; k < N; k++) sVld[k] = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1);
        check("final_drain", 64'(expQ.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
